pcs_tx_ordered_set_ctrl: RTL



---
 rtl/pcs_pkg.sv | 28 ++
 rtl/pcs_tx_ordered_set_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/pcs_pkg.sv
// Shared 1000BASE-X PCS definitions: code-group octets and transmit sequencer states.
package pcs_pkg;

  localparam logic [7:0] K28_5   = 8'hBC;
  localparam logic [7:0] K27_7_S = 8'hFB;
  localparam logic [7:0] K29_7_T = 8'hFD;
  localparam logic [7:0] K23_7_R = 8'hF7;
  localparam logic [7:0] K30_7_V = 8'hFE;
  localparam logic [7:0] D5_6    = 8'hC5;
  localparam logic [7:0] D16_2   = 8'h50;

  // Each state names the code-group currently presented to the encoder.
  typedef enum logic [2:0] {
    ST_IDLE_K = 3'd0,
    ST_IDLE_D = 3'd1,
    ST_SOP    = 3'd2,
    ST_DATA   = 3'd3,
    ST_EPD_T  = 3'd4,
    ST_EPD_R1 = 3'd5,
    ST_EPD_R2 = 3'd6
  } tx_os_state_e;

  // Second octet of the IDLE ordered set chosen from the running disparity.
  function automatic logic [7:0] idle_d_octet(input logic rd_pos);
    return rd_pos ? D5_6 : D16_2;
  endfunction

endpackage

// File: rtl/pcs_tx_ordered_set_ctrl.sv
// GMII-to-code-group transmit sequencer: IDLE, /S/, data, /V/, /T/R/(R) with
// even/odd alignment tracking and disparity-driven /I1/-/I2/ selection.
module pcs_tx_ordered_set_ctrl
  import pcs_pkg::*;
(
  input  logic       gtx_clk,
  input  logic       reset_n,
  input  logic [7:0] txd,
  input  logic       tx_en,
  input  logic       tx_er,
  input  logic       tx_rd_pos,
  output logic [7:0] tx_octet,
  output logic       tx_k,
  output logic       tx_even,
  output logic       transmitting
);

  tx_os_state_e r_state;
  logic [7:0]   r_octet;
  logic         r_k;
  logic         r_even;
  logic         r_trans;
  logic         r_pend;

  always_ff @(posedge gtx_clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE_K;
      r_octet <= K28_5;
      r_k     <= 1'b1;
      r_even  <= 1'b1;
      r_trans <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_even <= ~r_even;
      case (r_state)
        ST_IDLE_K: begin
          // A frame starting during the /K28.5/ is remembered so even a
          // one-cycle tx_en pulse yields /S/ at the next even slot.
          r_pend  <= tx_en;
          r_state <= ST_IDLE_D;
          r_octet <= idle_d_octet(tx_rd_pos);
          r_k     <= 1'b0;
        end
        ST_IDLE_D: begin
          r_pend <= 1'b0;
          r_k    <= 1'b1;
          if (tx_en || r_pend) begin
            r_state <= ST_SOP;
            r_octet <= K27_7_S;
            r_trans <= 1'b1;
          end else begin
            r_state <= ST_IDLE_K;
            r_octet <= K28_5;
          end
        end
        ST_SOP, ST_DATA: begin
          if (tx_en) begin
            r_state <= ST_DATA;
            r_octet <= tx_er ? K30_7_V : txd;
            r_k     <= tx_er;
          end else begin
            r_state <= ST_EPD_T;
            r_octet <= K29_7_T;
            r_k     <= 1'b1;
          end
        end
        ST_EPD_T: begin
          r_state <= ST_EPD_R1;
          r_octet <= K23_7_R;
          r_k     <= 1'b1;
        end
        ST_EPD_R1: begin
          r_k <= 1'b1;
          // A second /R/ pads an even-slot /R/ so IDLE restarts on even.
          if (r_even) begin
            r_state <= ST_EPD_R2;
            r_octet <= K23_7_R;
          end else begin
            r_state <= ST_IDLE_K;
            r_octet <= K28_5;
            r_trans <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE_K;
          r_octet <= K28_5;
          r_k     <= 1'b1;
          r_trans <= 1'b0;
        end
      endcase
    end
  end

  assign tx_octet     = r_octet;
  assign tx_k         = r_k;
  assign tx_even      = r_even;
  assign transmitting = r_trans;

endmodule
